// File: rtl/gpio_bank.sv
// gpio_bank: NPORTS x PORT_W GPIO controller with atomic set/clear, synchronised inputs and edge interrupts.
// Optional per-bit input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank #(
  parameter int NPORTS    = 3,
  parameter int PORT_W    = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [7:0]               addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic                     ack_o,
  output logic                     irq_o,
  input  logic [NPORTS*PORT_W-1:0] gpio_i,
  output logic [NPORTS*PORT_W-1:0] gpio_o,
  output logic [NPORTS*PORT_W-1:0] gpio_oe
);

  typedef logic [NPORTS-1:0][PORT_W-1:0] bank_t;

  typedef enum logic [2:0] {
    R_DIR      = 3'd0,
    R_OUT      = 3'd1,
    R_IN       = 3'd2,
    R_IRQ_EN   = 3'd3,
    R_IRQ_RISE = 3'd4,
    R_IRQ_STAT = 3'd5,
    R_OUT_SET  = 3'd6,
    R_OUT_CLR  = 3'd7
  } reg_t;

  logic              access;
  logic [2:0]        port_idx;
  reg_t              reg_idx;
  logic [PORT_W-1:0] wd;
  logic [NPORTS-1:0] port_hit;
  logic [NPORTS-1:0] wr_hit;
  logic [PORT_W-1:0] rd_val;
  logic              unused_bus_bits;

  bank_t dir_q, out_q, en_q, rise_q, stat_q, stat_d;
  bank_t sync1_q, sync2_q, filt, prev_q, evt;

  assign access          = sel_i & req_i;
  assign port_idx        = addr_i[7:5];
  assign reg_idx         = reg_t'(addr_i[4:2]);
  assign wd              = wdata_i[PORT_W-1:0];
  assign unused_bus_bits = ^{addr_i[1:0], wdata_i};

  // Ports at or above NPORTS never match, so such accesses only produce an ack (and zero read data).
  always_comb begin
    port_hit = '0;
    for (int p = 0; p < NPORTS; p++) begin
      port_hit[p] = access && (port_idx == 3'(p));
    end
  end

  assign wr_hit = port_hit & {NPORTS{we_i}};

  // Two-flop synchroniser on every pad input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] db_cnt [NPORTS][PORT_W];
  bank_t         filt_q;

  // A bit only follows the synchronised pin once it has disagreed for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        for (int b = 0; b < PORT_W; b++) begin
          db_cnt[p][b] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        for (int b = 0; b < PORT_W; b++) begin
          if (sync2_q[p][b] == filt_q[p][b]) begin
            db_cnt[p][b] <= '0;
          end else if (db_cnt[p][b] == DB_LAST) begin
            filt_q[p][b] <= sync2_q[p][b];
            db_cnt[p][b] <= '0;
          end else begin
            db_cnt[p][b] <= db_cnt[p][b] + CW'(1);
          end
        end
      end
    end
  end

  assign filt = filt_q;
`else
  localparam int unused_db_cycles = DB_CYCLES;

  assign filt = sync2_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= filt;
    end
  end

  assign evt = (rise_q & filt & ~prev_q) | (~rise_q & ~filt & prev_q);

  // A new enabled edge overrides a simultaneous write-1-to-clear on the same bit.
  always_comb begin
    stat_d = stat_q;
    for (int p = 0; p < NPORTS; p++) begin
      if (wr_hit[p] && (reg_idx == R_IRQ_STAT)) begin
        stat_d[p] = stat_d[p] & ~wd;
      end
      stat_d[p] = stat_d[p] | (evt[p] & en_q[p]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q  <= '0;
      out_q  <= '0;
      en_q   <= '0;
      rise_q <= '0;
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
      for (int p = 0; p < NPORTS; p++) begin
        if (wr_hit[p]) begin
          case (reg_idx)
            R_DIR:      dir_q[p]  <= wd;
            R_OUT:      out_q[p]  <= wd;
            R_IRQ_EN:   en_q[p]   <= wd;
            R_IRQ_RISE: rise_q[p] <= wd;
            R_OUT_SET:  out_q[p]  <= out_q[p] | wd;
            R_OUT_CLR:  out_q[p]  <= out_q[p] & ~wd;
            default:    ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_hit[p]) begin
        case (reg_idx)
          R_DIR:      rd_val = dir_q[p];
          R_OUT:      rd_val = out_q[p];
          R_IN:       rd_val = filt[p];
          R_IRQ_EN:   rd_val = en_q[p];
          R_IRQ_RISE: rd_val = rise_q[p];
          R_IRQ_STAT: rd_val = stat_q[p];
          default:    rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o   <= access;
      rdata_o <= (access && !we_i) ? 32'(rd_val) : 32'd0;
    end
  end

  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq_o   = |(stat_q & en_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (NPORTS=3, PORT_W=8).
// Debounce checks are included only when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_bank;

  localparam int NPORTS = 3;
  localparam int PORT_W = 8;
  localparam int W      = NPORTS * PORT_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel_i = 1'b0;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [7:0]    addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic [31:0]   rdata_o;
  logic          ack_o;
  logic          irq_o;
  logic [W-1:0]  gpio_i = '0;
  logic [W-1:0]  gpio_o;
  logic [W-1:0]  gpio_oe;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] rd;

  gpio_bank #(.NPORTS(NPORTS), .PORT_W(PORT_W), .DB_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .sel_i(sel_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o),
    .irq_o(irq_o), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_write(input logic [2:0] port, input logic [2:0] regi, input logic [31:0] data);
    @(negedge clk);
    sel_i = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = {port, regi, 2'b00}; wdata_i = data;
    @(posedge clk); #1;
    sel_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
    check_output("write_ack", 32'(ack_o), 32'd1);
  endtask

  task automatic apply_read(input logic [2:0] port, input logic [2:0] regi, output logic [31:0] data);
    @(negedge clk);
    sel_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = {port, regi, 2'b00}; wdata_i = '0;
    @(posedge clk); #1;
    sel_i = 1'b0; req_i = 1'b0;
    check_output("read_ack", 32'(ack_o), 32'd1);
    data = rdata_o;
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    wait_edges(2);
    check_output("rst_gpio_o", 32'(gpio_o), 32'd0);
    check_output("rst_gpio_oe", 32'(gpio_oe), 32'd0);
    check_output("rst_ack", 32'(ack_o), 32'd0);
    check_output("rst_irq", 32'(irq_o), 32'd0);
    check_output("rst_rdata", rdata_o, 32'd0);
    @(negedge clk); rst = 1'b0;

    // DIR/OUT write and readback on port 1
    apply_write(3'd1, 3'd0, 32'hFF);
    check_output("p1_oe", 32'(gpio_oe[15:8]), 32'hFF);
    apply_write(3'd1, 3'd1, 32'hA5);
    check_output("p1_out_pin", 32'(gpio_o[15:8]), 32'hA5);
    apply_read(3'd1, 3'd1, rd);
    check_output("p1_out_read", rd, 32'hA5);
    wait_edges(1);
    check_output("ack_pulse_drop", 32'(ack_o), 32'd0);
    check_output("rdata_idle_zero", rdata_o, 32'd0);

    // Atomic set/clear on port 0
    apply_write(3'd0, 3'd1, 32'h0F);
    apply_write(3'd0, 3'd6, 32'h30);
    apply_write(3'd0, 3'd7, 32'h01);
    apply_read(3'd0, 3'd1, rd);
    check_output("p0_out_setclr", rd, 32'h3E);
    check_output("p0_pin", 32'(gpio_o[7:0]), 32'h3E);
    apply_read(3'd0, 3'd6, rd);
    check_output("out_set_reads0", rd, 32'd0);
    apply_read(3'd0, 3'd7, rd);
    check_output("out_clr_reads0", rd, 32'd0);

    // Rising-edge interrupt on port 2 bit 0
    apply_write(3'd2, 3'd3, 32'h01);
    apply_write(3'd2, 3'd4, 32'h01);
    @(negedge clk); gpio_i[16] = 1'b1;
    wait_edges(1);
    check_output("irq_k", 32'(irq_o), 32'd0);
    wait_edges(1);
    check_output("irq_k1", 32'(irq_o), 32'd0);
    wait_edges(1);
    check_output("irq_k2", 32'(irq_o), 32'd1);
    apply_read(3'd2, 3'd5, rd);
    check_output("p2_stat", rd, 32'h01);
    apply_read(3'd2, 3'd2, rd);
    check_output("p2_in", rd, 32'h01);
    apply_write(3'd2, 3'd5, 32'h01);
    check_output("irq_w1c", 32'(irq_o), 32'd0);
    @(negedge clk); gpio_i[16] = 1'b0;
    wait_edges(4);
    check_output("irq_fall_ignored", 32'(irq_o), 32'd0);
    apply_read(3'd2, 3'd5, rd);
    check_output("stat_fall_ignored", rd, 32'd0);

    // W1C colliding with a new rising edge
    @(negedge clk); gpio_i[16] = 1'b1;
    wait_edges(3);
    @(negedge clk); gpio_i[16] = 1'b0;
    wait_edges(3);
    check_output("irq_held", 32'(irq_o), 32'd1);
    @(negedge clk); gpio_i[16] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    apply_write(3'd2, 3'd5, 32'h01);
    check_output("collide_irq", 32'(irq_o), 32'd1);
    apply_read(3'd2, 3'd5, rd);
    check_output("collide_stat", rd, 32'h01);
    apply_write(3'd2, 3'd5, 32'h01);
    check_output("clear_after_collide", 32'(irq_o), 32'd0);

    // Out-of-range port, RO write, request without select
    apply_write(3'd5, 3'd1, 32'hFF);
    check_output("p5_no_out", 32'(gpio_o), 32'h00A53E);
    check_output("p5_no_oe", 32'(gpio_oe), 32'h00FF00);
    apply_read(3'd5, 3'd1, rd);
    check_output("p5_read0", rd, 32'd0);
    apply_write(3'd2, 3'd2, 32'h00);
    apply_read(3'd2, 3'd2, rd);
    check_output("ro_in_unchanged", rd, 32'h01);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; sel_i = 1'b0; addr_i = {3'd0, 3'd1, 2'b00}; wdata_i = 32'h00;
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
    check_output("nosel_no_ack", 32'(ack_o), 32'd0);
    apply_read(3'd0, 3'd1, rd);
    check_output("nosel_no_write", rd, 32'h3E);

    // Falling-edge interrupt, then reset in the middle of an access
    apply_write(3'd2, 3'd4, 32'h00);
    @(negedge clk); gpio_i[16] = 1'b0;
    wait_edges(3);
    check_output("irq_fall", 32'(irq_o), 32'd1);
    @(negedge clk);
    sel_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = {3'd1, 3'd1, 2'b00};
    @(posedge clk); #1;
    sel_i = 1'b0; req_i = 1'b0;
    check_output("pre_rst_ack", 32'(ack_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_output("midrst_ack", 32'(ack_o), 32'd0);
    check_output("midrst_rdata", rdata_o, 32'd0);
    check_output("midrst_gpio_o", 32'(gpio_o), 32'd0);
    check_output("midrst_gpio_oe", 32'(gpio_oe), 32'd0);
    check_output("midrst_irq", 32'(irq_o), 32'd0);
    @(negedge clk); rst = 1'b0;
    apply_read(3'd1, 3'd1, rd);
    check_output("post_rst_out", rd, 32'd0);

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short glitch is filtered, long pulse passes
    apply_write(3'd0, 3'd3, 32'h01);
    apply_write(3'd0, 3'd4, 32'h01);
    @(negedge clk); gpio_i[0] = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    gpio_i[0] = 1'b0;
    wait_edges(25);
    apply_read(3'd0, 3'd2, rd);
    check_output("db_glitch_in", rd, 32'd0);
    check_output("db_glitch_irq", 32'(irq_o), 32'd0);
    @(negedge clk); gpio_i[0] = 1'b1;
    wait_edges(10);
    apply_read(3'd0, 3'd2, rd);
    check_output("db_early_in", rd, 32'd0);
    wait_edges(8);
    apply_read(3'd0, 3'd2, rd);
    check_output("db_late_in", rd, 32'h01);
    @(negedge clk); gpio_i[0] = 1'b0;
    check_output("db_irq", 32'(irq_o), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised multi-port GPIO controller: the next-generation replacement for the fixed three-port GPIO aggregation. It provides NPORTS ports of PORT_W bits behind a single data-bus slave select, with per-bit direction, atomic set/clear, two-flop input synchronisation, per-bit edge-selectable interrupts with write-1-to-clear status, and a single combined interrupt output. Pad tristating is done at chip top from `gpio_o`/`gpio_oe`.

## Interface

- `NPORTS`, 3: number of ports, 1..8.
- `PORT_W`, 8: bits per port, 1..32.
- `DB_CYCLES`, 16: debounce stability count; used only with the debounce macro.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sel_i`  in  1  slave select from the bus decoder.
- `req_i`  in  1  access strobe, one cycle per access, valid only with `sel_i`.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  8  byte address. [7:5] is the port index, [4:2] is the register index, [1:0] is ignored.
- `wdata_i`  in  32  write data; bits above PORT_W are ignored.
- `rdata_o`  out  32  read data, zero-extended.
- `ack_o`  out  1  access complete, one-cycle pulse.
- `irq_o`  out  1  OR over all ports of (IRQ_STAT & IRQ_EN).
- `gpio_i`  in  NPORTS*PORT_W  pad inputs. Port p occupies bits [p*PORT_W +: PORT_W].
- `gpio_o`  out  NPORTS*PORT_W  pad output values (the OUT registers).
- `gpio_oe`  out  NPORTS*PORT_W  output enables (the DIR registers). 1 = output, 0 = input.

## Operation

Per-port registers, selected by register index:
- 0 DIR: RW.
- 1 OUT: RW.
- 2 IN: RO. Synchronised (and, with the macro, debounced) pin value.
- 3 IRQ_EN: RW.
- 4 IRQ_RISE: RW. 1 = rising edge, 0 = falling edge.
- 5 IRQ_STAT: W1C.
- 6 OUT_SET: WO. OUT |= wdata. Reads 0.
- 7 OUT_CLR: WO. OUT &= ~wdata. Reads 0.

Access and decode rules:
- IN reflects the pin for every bit, including output bits (loopback).
- Edge detect per bit compares the filtered input against its previous-cycle copy.
- IRQ_STAT[b] sets only when a selected-polarity edge occurs and IRQ_EN[b] = 1. Clearing IRQ_EN does not clear STAT.
- A W1C write and a new edge on the same bit in the same cycle: the edge wins and the bit stays 1.
- A port index ≥ NPORTS: the write is ignored, a read returns 0, and the access is still acked.
- A write to a RO register is ignored. It is acked.
- `req_i` without `sel_i` is ignored: no ack and no state change.

Reset values:
- All registers are 0.
- The synchroniser and previous-value flops are 0.
- `gpio_o` = 0, `gpio_oe` = 0, `rdata_o` = 0, `ack_o` = 0, `irq_o` = 0.
- The first synchronised 1 after reset is a rising edge, but it does not set STAT because IRQ_EN = 0 out of reset.

## Timing

- **Bus access:** request on edge k; `ack_o` high for the cycle after edge k; `rdata_o` is valid in that same cycle and 0 otherwise.
  - A write takes effect at edge k, so `gpio_o`/`gpio_oe` change after edge k.
  - Back-to-back requests are allowed, one per cycle, each acked one cycle later.
- **Input path:** pin stable from before edge k.
  - Synchroniser output updates at edge k+1.
  - IN is readable from the cycle after edge k+1.
  - IRQ_STAT sets at edge k+2, and `irq_o` rises in that cycle.
- `irq_o` is combinational from registered STAT and EN. It drops in the cycle after the W1C write edge.
- **Reset mid-access:** asserting `rst` forces `ack_o` = 0 immediately; the pending ack is lost.

## Configuration

- **`GPIO_DEBOUNCE_EN` defined:**
  - Each bit has a counter of width $clog2(DB_CYCLES+1).
  - The counter resets to 0 whenever the synchronised value equals the filtered value, and increments otherwise.
  - When the counter reaches DB_CYCLES-1, the filtered value takes the synchronised value and the counter clears.
  - Input-to-IN latency is 2 + DB_CYCLES cycles. Glitches shorter than DB_CYCLES cycles are invisible to IN and to the IRQ logic.
- **Not defined:** filtered value = synchronised value. No counters are instantiated; latency is as in Timing.

## Test plan

- Write DIR port1 = 0xFF, then OUT port1 = 0xA5 → `gpio_oe[15:8]` = 0xFF, `gpio_o[15:8]` = 0xA5. Readback of OUT = 0xA5 with `ack_o` one cycle after `req_i`.
- OUT port0 = 0x0F, OUT_SET 0x30, then OUT_CLR 0x01 → OUT reads 0x3E. OUT_SET and OUT_CLR each read 0.
- IRQ_EN port2 = 0x01, IRQ_RISE = 0x01; drive `gpio_i[16]` 0→1 → STAT port2 = 0x01 and `irq_o` = 1 two edges after the pin change. Write STAT 0x01 → `irq_o` = 0 the next cycle. A falling edge does not set STAT.
- Issue a W1C to STAT bit 0 in the same cycle as a new rising edge on that bit → STAT bit stays 1 and `irq_o` stays 1.
- Read and write port index 5 with NPORTS = 3 → read returns 0, no register changes, ack still given. Assert `rst` mid-access → all outputs are 0 at once.
- With `GPIO_DEBOUNCE_EN` and DB_CYCLES = 16:
  - A 10-cycle pulse on `gpio_i[0]` → IN and STAT unchanged.
  - A 20-cycle pulse → IN bit 0 = 1 at 18 cycles after the pin change.
